sipo: RTL and testbench

//  Serial-in/parallel-out receiver. Receive end of the LSB-first shift link driven by the piso transmitter.

---
 rtl/serial_pkg.sv | 18 +
 rtl/sipo_bit_counter.sv | 45 ++++
 rtl/sipo.sv | 91 +++++++++
 tb/tb_sipo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Definitions shared by the piso transmitter and the sipo receiver of the serial link.
// Covers the bit order on the wire, the default word width and counter sizing.
package serial_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    localparam bit_order_e  SERIAL_BIT_ORDER     = LSB_FIRST;
    localparam int unsigned SERIAL_WIDTH_DEFAULT = 16;

    // Bit-counter width for a given word width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted serial bits and flags the bit that completes a word.
// The count wraps to zero on that bit; clear has priority over enable.
module sipo_bit_counter
    import serial_pkg::*;
#(
    parameter logic [7:0] WIDTH = 8'(SERIAL_WIDTH_DEFAULT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int unsigned       CNT_W = cnt_width(int'(WIDTH));
    // Explicit terminal compare, so widths that are not powers of two wrap correctly.
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(int'(WIDTH) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign wrap_o  = en_i && !clr_i && at_last;

    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out receiver for the LSB-first link, with a single output holding register
// presented on a valid/ready interface and a sticky overrun flag for dropped words.
module sipo
    import serial_pkg::*;
#(
    parameter logic [7:0] DATA_WIDTH = 8'(SERIAL_WIDTH_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_i,
    input  logic                  shift_en_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  word_done;
    logic                  slot_free;

    sipo_bit_counter #(
        .WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (shift_en_i),
        .clr_i  (flush_i),
        .wrap_o (word_done)
    );

    // New bits enter at the top and walk down, so the first bit received ends up in bit 0.
    assign shifted   = {serial_i, shreg_q[DATA_WIDTH-1:1]};
    assign slot_free = !valid_q || ready_i;

    always_comb begin
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (flush_i) begin
            shreg_d = '0;
        end else if (shift_en_i) begin
            shreg_d = shifted;
        end

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // A completed word either lands in the holding register or is dropped and flagged.
        if (word_done) begin
            if (slot_free) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed scenarios plus random traffic against a
// queue-based word-assembly model.
module tb_sipo;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         serial_i;
    logic         shift_en_i;
    logic         flush_i;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         overrun_o;

    int total = 0;
    int bad   = 0;

    // Reference model: received bits kept in arrival order, plus the output slot.
    bit           m_bits[$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_overrun;

    sipo #(
        .DATA_WIDTH (8'd16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_i   (serial_i),
        .shift_en_i (shift_en_i),
        .flush_i    (flush_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overrun_o  (overrun_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_bits.delete();
        m_valid   = 1'b0;
        m_data    = '0;
        m_overrun = 1'b0;
    endtask

    // One clock: drive inputs at the negedge, update the model at the posedge, return at the next negedge.
    task automatic cycle(input logic s, input logic en, input logic fl, input logic rdy);
        logic [W-1:0] word;
        logic         done;
        logic         free;
        serial_i   = s;
        shift_en_i = en;
        flush_i    = fl;
        ready_i    = rdy;
        @(posedge clk);
        done = 1'b0;
        word = '0;
        if (fl) begin
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
                for (int k = 0; k < W; k++) word[k] = m_bits[k];
                m_bits.delete();
                done = 1'b1;
            end
        end
        free = !m_valid || rdy;
        if (m_valid && rdy) m_valid = 1'b0;
        if (done) begin
            if (free) begin
                m_data  = word;
                m_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gaps, input logic rdy, input logic last_rdy);
        for (int k = 0; k < W; k++) begin
            if (gaps) repeat ($urandom_range(0, 3)) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
            cycle(w[k], 1'b1, 1'b0, (k == W - 1) ? last_rdy : rdy);
        end
    endtask

    task automatic apply_reset();
        serial_i   = 1'b0;
        shift_en_i = 1'b0;
        flush_i    = 1'b0;
        ready_i    = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state: got v=%b o=%b d=%h want v=0 o=0 d=0000", valid_o, overrun_o, data_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            total++;
            if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'h0000}) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got v=%b o=%b d=%h want v=0 o=0 d=0000", i, valid_o, overrun_o, data_o);
            end
        end
    endtask

    task automatic test_basic();
        send_word(16'hA5C3, 1'b0, 1'b1, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'hA5C3}) begin
            bad++;
            $display("FAIL basic_word: got v=%b o=%b d=%h want v=1 o=0 d=a5c3", valid_o, overrun_o, data_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'hA5C3}) begin
            bad++;
            $display("FAIL basic_consumed: got v=%b o=%b d=%h want v=0 o=0 d=a5c3", valid_o, overrun_o, data_o);
        end
    endtask

    task automatic test_gaps();
        send_word(16'hA5C3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'hA5C3}) begin
                bad++;
                $display("FAIL gaps_hold[%0d]: got v=%b o=%b d=%h want v=1 o=0 d=a5c3", i, valid_o, overrun_o, data_o);
            end
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'hA5C3}) begin
            bad++;
            $display("FAIL gaps_consumed: got v=%b o=%b d=%h want v=0 o=0 d=a5c3", valid_o, overrun_o, data_o);
        end
    endtask

    task automatic test_overrun();
        send_word(16'h1234, 1'b0, 1'b0, 1'b0);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'h1234}) begin
            bad++;
            $display("FAIL overrun_first: got v=%b o=%b d=%h want v=1 o=0 d=1234", valid_o, overrun_o, data_o);
        end
        send_word(16'hFFFF, 1'b0, 1'b0, 1'b0);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b1, 16'h1234}) begin
            bad++;
            $display("FAIL overrun_drop: got v=%b o=%b d=%h want v=1 o=1 d=1234", valid_o, overrun_o, data_o);
        end
        send_word(16'h0F0F, 1'b0, 1'b1, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b1, 16'h0F0F}) begin
            bad++;
            $display("FAIL overrun_sticky: got v=%b o=%b d=%h want v=1 o=1 d=0f0f", valid_o, overrun_o, data_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b1, 16'h0F0F}) begin
            bad++;
            $display("FAIL overrun_consumed: got v=%b o=%b d=%h want v=0 o=1 d=0f0f", valid_o, overrun_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_word(16'h1111, 1'b0, 1'b0, 1'b0);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'h1111}) begin
            bad++;
            $display("FAIL b2b_first: got v=%b o=%b d=%h want v=1 o=0 d=1111", valid_o, overrun_o, data_o);
        end
        send_word(16'h00FF, 1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'h00FF}) begin
            bad++;
            $display("FAIL b2b_second: got v=%b o=%b d=%h want v=1 o=0 d=00ff", valid_o, overrun_o, data_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'h00FF}) begin
            bad++;
            $display("FAIL b2b_consumed: got v=%b o=%b d=%h want v=0 o=0 d=00ff", valid_o, overrun_o, data_o);
        end
    endtask

    task automatic test_flush_and_reset();
        for (int k = 0; k < 7; k++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'h00FF}) begin
            bad++;
            $display("FAIL flush_outputs: got v=%b o=%b d=%h want v=0 o=0 d=00ff", valid_o, overrun_o, data_o);
        end
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(16'hBEEF, 1'b0, 1'b1, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'hBEEF}) begin
            bad++;
            $display("FAIL flush_word: got v=%b o=%b d=%h want v=1 o=0 d=beef", valid_o, overrun_o, data_o);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(16'h5A5A, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL midword_reset: got v=%b o=%b d=%h want v=0 o=0 d=0000", valid_o, overrun_o, data_o);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(16'hC0DE, 1'b0, 1'b1, 1'b1);
        total++;
        if ({valid_o, overrun_o, data_o} !== {1'b1, 1'b0, 16'hC0DE}) begin
            bad++;
            $display("FAIL after_reset_word: got v=%b o=%b d=%h want v=1 o=0 d=c0de", valid_o, overrun_o, data_o);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 2) == 0));
            total++;
            if ({valid_o, overrun_o, data_o} !== {m_valid, m_overrun, m_data}) begin
                bad++;
                $display("FAIL random[%0d]: got v=%b o=%b d=%h want v=%b o=%b d=%h",
                         i, valid_o, overrun_o, data_o, m_valid, m_overrun, m_data);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        serial_i   = 1'b0;
        shift_en_i = 1'b0;
        flush_i    = 1'b0;
        ready_i    = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_flush_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
